// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: valid/ready event handshake between the arbiter and its consumer.
interface button_event_arbiter_if #(
    parameter int IDW = 2
) ();
    logic           ev_valid;
    logic [IDW-1:0] ev_id;
    logic           ev_ready;

    modport master (output ev_valid, ev_id, input ev_ready);
    modport slave  (input ev_valid, ev_id, output ev_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: round-robin serialiser of single-cycle button events with
// one pending slot per requester and a saturating drop counter.
module button_event_arbiter #(
    parameter int N    = 4,
    parameter int IDW  = $clog2(N),
    parameter int CNTW = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N-1:0]           evt,
    button_event_arbiter_if.master ev,
    output logic [N-1:0]           pending,
    output logic [CNTW-1:0]        drop_cnt,
    output logic                   busy
);
    localparam int MAXC = (1 << CNTW) - 1;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state, state_nx;
    logic            valid_q, valid_nx;
    logic [IDW-1:0]  id_q, id_nx, rr_ptr, rr_nx, pick;
    logic [N-1:0]    acc_vec, drops, pending_nx;
    logic [CNTW-1:0] cnt_nx;
    int              ndrop, sum;

    // An event arriving for the requester being accepted refills its slot instead of dropping.
    always_comb begin
        acc_vec = '0;
        for (int i = 0; i < N; i++) acc_vec[i] = valid_q & ev.ev_ready & (id_q == IDW'(i));
        drops      = evt & pending & ~acc_vec;
        pending_nx = (pending & ~acc_vec) | evt;
        ndrop = 0;
        for (int i = 0; i < N; i++) if (drops[i]) ndrop++;
        sum    = int'(drop_cnt) + ndrop;
        cnt_nx = (sum > MAXC) ? CNTW'(MAXC) : CNTW'(sum);
    end

    // Scan from far to near so the nearest pending bit at or after rr_ptr wins.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--)
            if (pending[(int'(rr_ptr) + k) % N]) pick = IDW'((int'(rr_ptr) + k) % N);
    end

    always_comb begin
        state_nx = state;
        valid_nx = valid_q;
        id_nx    = id_q;
        rr_nx    = rr_ptr;
        if (state == IDLE) begin
            if (|pending) begin
                state_nx = OFFER;
                valid_nx = 1'b1;
                id_nx    = pick;
            end
        end else if (ev.ev_ready) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            rr_nx    = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            id_q     <= '0;
            rr_ptr   <= '0;
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            valid_q  <= valid_nx;
            id_q     <= id_nx;
            rr_ptr   <= rr_nx;
            pending  <= pending_nx;
            drop_cnt <= cnt_nx;
        end
    end

    assign ev.ev_valid = valid_q;
    assign ev.ev_id    = id_q;
    assign busy        = valid_q | (|pending);
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed vector table plus hand-written sequences for
// backpressure, drops, saturation (CNTW=3) and asynchronous reset.
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] evt = '0;
    logic [3:0] pending;
    logic [2:0] drop_cnt;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;

    button_event_arbiter_if #(.IDW(2)) ev_if ();

    button_event_arbiter #(.N(4), .IDW(2), .CNTW(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .evt      (evt),
        .ev       (ev_if.master),
        .pending  (pending),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] evt;
        logic       rdy;
        logic       valid;
        logic [1:0] id;
        logic [3:0] pend;
        logic [2:0] drop;
        logic       busy;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        logic [3:0] seq[6];
        // single event, then 1111 from rr_ptr=3, then reposition to rr_ptr=0 and 1111 again
        tbl[0]  = '{4'b0100, 1, 0, 0, 4'b0100, 0, 1};
        tbl[1]  = '{4'b0000, 1, 1, 2, 4'b0100, 0, 1};
        tbl[2]  = '{4'b0000, 1, 0, 2, 4'b0000, 0, 0};
        tbl[3]  = '{4'b1111, 1, 0, 2, 4'b1111, 0, 1};
        tbl[4]  = '{4'b0000, 1, 1, 3, 4'b1111, 0, 1};
        tbl[5]  = '{4'b0000, 1, 0, 3, 4'b0111, 0, 1};
        tbl[6]  = '{4'b0000, 1, 1, 0, 4'b0111, 0, 1};
        tbl[7]  = '{4'b0000, 1, 0, 0, 4'b0110, 0, 1};
        tbl[8]  = '{4'b0000, 1, 1, 1, 4'b0110, 0, 1};
        tbl[9]  = '{4'b0000, 1, 0, 1, 4'b0100, 0, 1};
        tbl[10] = '{4'b0000, 1, 1, 2, 4'b0100, 0, 1};
        tbl[11] = '{4'b0000, 1, 0, 2, 4'b0000, 0, 0};
        tbl[12] = '{4'b1000, 1, 0, 2, 4'b1000, 0, 1};
        tbl[13] = '{4'b0000, 1, 1, 3, 4'b1000, 0, 1};
        tbl[14] = '{4'b0000, 1, 0, 3, 4'b0000, 0, 0};
        tbl[15] = '{4'b1111, 1, 0, 3, 4'b1111, 0, 1};
        tbl[16] = '{4'b0000, 1, 1, 0, 4'b1111, 0, 1};
        tbl[17] = '{4'b0000, 1, 0, 0, 4'b1110, 0, 1};
        tbl[18] = '{4'b0000, 1, 1, 1, 4'b1110, 0, 1};
        tbl[19] = '{4'b0000, 1, 0, 1, 4'b1100, 0, 1};
        tbl[20] = '{4'b0000, 1, 1, 2, 4'b1100, 0, 1};
        tbl[21] = '{4'b0000, 1, 0, 2, 4'b1000, 0, 1};
        tbl[22] = '{4'b0000, 1, 1, 3, 4'b1000, 0, 1};
        tbl[23] = '{4'b0000, 1, 0, 3, 4'b0000, 0, 0};

        ev_if.ev_ready = 1'b0;
        // reset held while evt toggles
        for (int i = 0; i < 4; i++) begin
            evt = 4'(i * 5 + 3);
            ev_if.ev_ready = i[0];
            step();
            chk("rst_valid", 32'(ev_if.ev_valid), 0);
            chk("rst_id", 32'(ev_if.ev_id), 0);
            chk("rst_pend", 32'(pending), 0);
            chk("rst_drop", 32'(drop_cnt), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        evt = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", 32'(ev_if.ev_valid), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        foreach (tbl[i]) begin
            evt = tbl[i].evt;
            ev_if.ev_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(ev_if.ev_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d_id", i), 32'(ev_if.ev_id), 32'(tbl[i].id));
            chk($sformatf("v%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        // backpressure with id 1 offered; evt[1] pulses while it is still pending
        ev_if.ev_ready = 1'b0;
        evt = 4'b0010;
        step();
        chk("bp_pend", 32'(pending), 32'b0010);
        evt = '0;
        step();
        chk("bp_offer_valid", 32'(ev_if.ev_valid), 1);
        chk("bp_offer_id", 32'(ev_if.ev_id), 1);
        for (int i = 0; i < 10; i++) begin
            evt = (i == 2 || i == 5) ? 4'b0010 : 4'b0000;
            step();
            chk("bp_hold_valid", 32'(ev_if.ev_valid), 1);
            chk("bp_hold_id", 32'(ev_if.ev_id), 1);
        end
        chk("bp_drop", 32'(drop_cnt), 2);
        evt = 4'b0010;
        ev_if.ev_ready = 1'b1;
        step();
        chk("acc_valid", 32'(ev_if.ev_valid), 0);
        chk("acc_pend", 32'(pending), 32'b0010);
        chk("acc_drop", 32'(drop_cnt), 2);
        evt = '0;
        step();
        chk("reoffer_valid", 32'(ev_if.ev_valid), 1);
        chk("reoffer_id", 32'(ev_if.ev_id), 1);
        step();
        chk("reacc_valid", 32'(ev_if.ev_valid), 0);
        chk("reacc_busy", 32'(busy), 0);

        // asynchronous reset in the middle of an offer
        ev_if.ev_ready = 1'b0;
        evt = 4'b0001;
        step();
        evt = 4'b0100;
        step();
        chk("mid_valid", 32'(ev_if.ev_valid), 1);
        chk("mid_pend", 32'(pending), 32'b0101);
        evt = '0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ev_if.ev_valid), 0);
        chk("arst_pend", 32'(pending), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        chk("arst_busy", 32'(busy), 0);
        step();
        step();
        reset_n = 1'b1;

        // saturation at 2**3-1, including two drops in one cycle
        evt = 4'b0011;
        step();
        chk("sat_pend", 32'(pending), 32'b0011);
        seq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001};
        acc = 0;
        foreach (seq[i]) begin
            evt = seq[i];
            acc += $countones(seq[i]);
            step();
            chk($sformatf("sat%0d_drop", i), 32'(drop_cnt), (acc > 7) ? 7 : acc);
        end
        chk("sat_id", 32'(ev_if.ev_id), 0);
        evt = '0;
        ev_if.ev_ready = 1'b1;
        step();
        chk("sat_acc_valid", 32'(ev_if.ev_valid), 0);
        chk("sat_acc_pend", 32'(pending), 32'b0010);
        chk("sat_acc_drop", 32'(drop_cnt), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
